// File: rtl/hcsr04_pkg.sv
// Shared constants, state codes and channel-search helper for the multi-channel ultrasonic ranger.
package hcsr04_pkg;

  localparam int unsigned DEF_TRIG_CYCLES = 500;
  localparam int unsigned DEF_MM_CYCLES   = 292;
  localparam int unsigned DEF_MAX_MM      = 4000;
  localparam int unsigned DEF_WAIT_CYCLES = 1_500_000;
  localparam int unsigned DEF_GAP_CYCLES  = 3_000_000;
  localparam int unsigned CNT_W           = 32;
  localparam int unsigned MAX_CH          = 8;
  localparam logic [3:0]  CH_NONE         = 4'd8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TRIG = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_MEAS = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  // Lowest enabled channel at or above 'from'; CH_NONE when there is none.
  function automatic logic [3:0] next_en(input logic [MAX_CH-1:0] mask, input logic [3:0] from);
    next_en = CH_NONE;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) next_en = 4'(i);
    end
  endfunction

endpackage

// File: rtl/hcsr04_sync.sv
// Two-flop synchroniser for the asynchronous echo pins.
module hcsr04_sync
  import hcsr04_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/hcsr04_scan.sv
// Round-robin HC-SR04 ranging engine: trig, echo wait, echo-width to mm conversion,
// timeout / over-range flagging and inter-ping quiet gap.
module hcsr04_scan
  import hcsr04_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned TRIG_CYCLES = DEF_TRIG_CYCLES,
  parameter int unsigned MM_CYCLES   = DEF_MM_CYCLES,
  parameter int unsigned MAX_MM      = DEF_MAX_MM,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned DW          = 12,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_cont,
  input  logic [N_CH-1:0] i_ch_en,
  input  logic [N_CH-1:0] i_echo,
  output logic [N_CH-1:0] o_trig,
  output logic [DW-1:0]   o_distance,
  output logic [CH_W-1:0] o_ch,
  output logic            o_err,
  output logic            o_val,
  output logic            o_busy
);

  logic [2:0]       r_state,  w_state_nxt;
  logic [CH_W-1:0]  r_sel,    w_sel_nxt;
  logic [N_CH-1:0]  r_mask,   w_mask_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [DW-1:0]    r_mm,     w_mm_nxt;
  logic [N_CH-1:0]  r_trig,   w_trig_nxt;
  logic [DW-1:0]    r_dist,   w_dist_nxt;
  logic [CH_W-1:0]  r_ch,     w_ch_nxt;
  logic             r_err,    w_err_nxt;
  logic             r_val,    w_val_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_echo_prev;
  logic [N_CH-1:0]  w_echo_sync;
  logic             w_echo_sel;
  logic [3:0]       w_first;
  logic [3:0]       w_next;

  hcsr04_sync #(.W(N_CH)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_echo),
    .o_q   (w_echo_sync)
  );

  assign w_echo_sel = w_echo_sync[r_sel];
  assign w_first    = next_en(MAX_CH'(i_ch_en), 4'd0);
  assign w_next     = next_en(MAX_CH'(r_mask), 4'(r_sel) + 4'd1);

  // One shared counter: trig width, echo wait, per-mm sub-count, gap.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_mm_nxt    = r_mm;
    w_dist_nxt  = r_dist;
    w_ch_nxt    = r_ch;
    w_err_nxt   = r_err;
    w_val_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (i_start && (i_ch_en != '0)) begin
          w_state_nxt = ST_TRIG;
          w_mask_nxt  = i_ch_en;
          w_sel_nxt   = CH_W'(w_first);
        end
      end
      ST_TRIG: begin
        if (r_cnt == CNT_W'(TRIG_CYCLES - 1)) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (w_echo_sel && !r_echo_prev) begin
          w_state_nxt = ST_MEAS;
          w_cnt_nxt   = '0;
          w_mm_nxt    = '0;
        end else if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
          w_dist_nxt  = '0;
          w_ch_nxt    = r_sel;
          w_err_nxt   = 1'b1;
          w_val_nxt   = 1'b1;
        end
      end
      ST_MEAS: begin
        if (!w_echo_sel) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
          w_dist_nxt  = r_mm;
          w_ch_nxt    = r_sel;
          w_err_nxt   = 1'b0;
          w_val_nxt   = 1'b1;
        end else if (r_cnt == CNT_W'(MM_CYCLES - 1)) begin
          w_cnt_nxt = '0;
          if (r_mm == DW'(MAX_MM - 1)) begin
            w_state_nxt = ST_GAP;
            w_dist_nxt  = DW'(MAX_MM);
            w_ch_nxt    = r_sel;
            w_err_nxt   = 1'b1;
            w_val_nxt   = 1'b1;
          end else begin
            w_mm_nxt = r_mm + DW'(1);
          end
        end
      end
      ST_GAP: begin
        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          w_cnt_nxt = '0;
          if (w_next != CH_NONE) begin
            w_state_nxt = ST_TRIG;
            w_sel_nxt   = CH_W'(w_next);
          end else if (i_cont && (i_ch_en != '0)) begin
            w_state_nxt = ST_TRIG;
            w_mask_nxt  = i_ch_en;
            w_sel_nxt   = CH_W'(w_first);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_trig_nxt = (w_state_nxt == ST_TRIG) ? (N_CH'(1'b1) << w_sel_nxt) : '0;
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_mask      <= '0;
      r_cnt       <= '0;
      r_mm        <= '0;
      r_trig      <= '0;
      r_dist      <= '0;
      r_ch        <= '0;
      r_err       <= 1'b0;
      r_val       <= 1'b0;
      r_busy      <= 1'b0;
      r_echo_prev <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_mask      <= w_mask_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mm        <= w_mm_nxt;
      r_trig      <= w_trig_nxt;
      r_dist      <= w_dist_nxt;
      r_ch        <= w_ch_nxt;
      r_err       <= w_err_nxt;
      r_val       <= w_val_nxt;
      r_busy      <= w_busy_nxt;
      r_echo_prev <= w_echo_sel;
    end
  end

  assign o_trig     = r_trig;
  assign o_distance = r_dist;
  assign o_ch       = r_ch;
  assign o_err      = r_err;
  assign o_val      = r_val;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_hcsr04_scan.sv
// Bench for hcsr04_scan with shortened timing; a responder plays the sensors and
// predicts each result, a compare process checks every val strobe against it.
module tb_hcsr04_scan;

  localparam int NCH   = 4;
  localparam int T     = 5;
  localparam int MM    = 10;
  localparam int MAXMM = 400;
  localparam int WAITC = 300;
  localparam int GAPC  = 200;
  localparam int DW    = 12;

  typedef struct {
    int ch;
    int dist_lo;
    int dist_hi;
    int err;
    int t_lo;
    int t_hi;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           cont;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] echo;
  logic [NCH-1:0] trig;
  logic [DW-1:0]  distance;
  logic [1:0]     ch;
  logic           err;
  logic           val;
  logic           busy;

  exp_t exp_q[$];
  int   trig_q[$];
  int   dly[NCH];
  int   wid[NCH];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   val_cnt = 0;
  int   last_val_cyc = 0;
  bit   seen_val = 1'b0;
  exp_t ce;

  hcsr04_scan #(
    .N_CH(NCH), .TRIG_CYCLES(T), .MM_CYCLES(MM), .MAX_MM(MAXMM),
    .WAIT_CYCLES(WAITC), .GAP_CYCLES(GAPC), .DW(DW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cont(cont),
    .i_ch_en(ch_en), .i_echo(echo), .o_trig(trig), .o_distance(distance),
    .o_ch(ch), .o_err(err), .o_val(val), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: actual %0d, required %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Sensor model: answers each trig with the programmed echo and predicts the result.
  initial begin : responder
    echo = '0;
    forever begin
      @(negedge clk);
      if (trig != '0) begin : ping
        int   c;
        int   tw;
        int   t0;
        int   nc;
        exp_t e;
        c = 0;
        for (int i = 0; i < NCH; i++) if (trig[i]) c = i;
        tw = 0;
        while (trig != '0 && tw < 1000) begin
          tw++;
          @(negedge clk);
        end
        chk("trig_width", tw, T);
        trig_q.push_back(c);
        t0 = cyc;
        e.ch = c;
        if (wid[c] == 0) begin
          e.dist_lo = 0; e.dist_hi = 0; e.err = 1;
          e.t_lo = t0 + WAITC; e.t_hi = e.t_lo;
        end else if (wid[c] / MM >= MAXMM) begin
          e.dist_lo = MAXMM; e.dist_hi = MAXMM; e.err = 1;
          e.t_lo = t0 + dly[c] + MAXMM * MM; e.t_hi = e.t_lo + 4;
        end else begin
          e.dist_lo = wid[c] / MM - 1; e.dist_hi = wid[c] / MM + 1; e.err = 0;
          e.t_lo = t0 + dly[c] + wid[c] + 3; e.t_hi = e.t_lo;
        end
        exp_q.push_back(e);
        if (wid[c] != 0) begin
          nc = c ^ 2;
          if (dly[c] >= 5) begin
            echo[nc] = 1'b1;
            repeat (3) @(negedge clk);
            echo[nc] = 1'b0;
            repeat (dly[c] - 3) @(negedge clk);
          end else begin
            repeat (dly[c]) @(negedge clk);
          end
          echo[c] = 1'b1;
          repeat (wid[c]) @(negedge clk);
          echo[c] = 1'b0;
        end
      end
    end
  end

  // Per-cycle output checks against the predicted results.
  always @(negedge clk) begin
    chk("trig_onehot0", int'($onehot0(trig)), 1);
    if (val) begin
      val_cnt++;
      if (seen_val) chk_rng("val_spacing", cyc - last_val_cyc, GAPC + 1, 1 << 30);
      seen_val     = 1'b1;
      last_val_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_val: actual ch=%0d distance=%0d err=%0d, required no val", ch, distance, err);
      end else begin
        ce = exp_q.pop_front();
        chk("val_ch", int'(ch), ce.ch);
        chk("val_err", int'(err), ce.err);
        chk_rng("val_distance", int'(distance), ce.dist_lo, ce.dist_hi);
        chk_rng("val_time", cyc, ce.t_lo, ce.t_hi);
      end
    end
  end

  task automatic sweep(input logic [NCH-1:0] m, input logic c);
    ch_en = m;
    cont  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  initial begin : watchdog
    #(60000 * 10);
    n_err++;
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int v0;
    int n;
    rst = 1'b0; start = 1'b0; cont = 1'b0; ch_en = '0;
    for (int i = 0; i < NCH; i++) begin
      dly[i] = 20;
      wid[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_trig", int'(trig), 0);
    chk("rst_distance", int'(distance), 0);
    chk("rst_ch", int'(ch), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_val", int'(val), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single enabled channel, normal echo.
    dly[0] = 20; wid[0] = 855;
    v0 = val_cnt;
    sweep(4'b0001, 1'b0);
    chk("start_latency_trig", int'(trig), 1);
    chk("start_busy", int'(busy), 1);
    wait_idle(5000);
    chk("A_distance", int'(distance), 85);
    chk("A_ch", int'(ch), 0);
    chk("A_err", int'(err), 0);
    chk("A_val_count", val_cnt - v0, 1);
    chk("A_pending", exp_q.size(), 0);

    // Sparse mask, mid-sweep start and mask change must be ignored.
    dly[1] = 20; wid[1] = 855;
    dly[3] = 30; wid[3] = 3065;
    trig_q.delete();
    v0 = val_cnt;
    sweep(4'b1010, 1'b0);
    repeat (50) @(negedge clk);
    ch_en = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ch_en = 4'b1111;
    wait_idle(20000);
    chk("B_order_len", trig_q.size(), 2);
    chk("B_order0", (trig_q.size() > 0) ? trig_q[0] : -1, 1);
    chk("B_order1", (trig_q.size() > 1) ? trig_q[1] : -1, 3);
    chk("B_distance", int'(distance), 306);
    chk("B_ch", int'(ch), 3);
    chk("B_val_count", val_cnt - v0, 2);

    // Echo never rises: timeout result.
    wid[2] = 0;
    sweep(4'b0100, 1'b0);
    wait_idle(5000);
    chk("TO_distance", int'(distance), 0);
    chk("TO_err", int'(err), 1);
    chk("TO_ch", int'(ch), 2);

    // Echo held far beyond range: saturated over-range result.
    dly[0] = 10; wid[0] = 4100;
    sweep(4'b0001, 1'b0);
    wait_idle(10000);
    chk("OR_distance", int'(distance), MAXMM);
    chk("OR_err", int'(err), 1);
    chk("OR_ch", int'(ch), 0);
    repeat (20) @(negedge clk);

    // Continuous sweeping, stopped during the third sweep.
    dly[0] = 10; wid[0] = 55;
    dly[1] = 10; wid[1] = 123;
    trig_q.delete();
    sweep(4'b0011, 1'b1);
    n = 0;
    while (trig_q.size() < 5 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    cont = 1'b0;
    wait_idle(20000);
    chk("C_order_len", trig_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("C_order", (trig_q.size() > i) ? trig_q[i] : -1, i % 2);
    chk("C_distance", int'(distance), 12);
    chk("C_ch", int'(ch), 1);

    // Start with empty mask is ignored.
    sweep(4'b0000, 1'b0);
    chk("E_busy0", int'(busy), 0);
    repeat (5) @(negedge clk);
    chk("E_busy1", int'(busy), 0);
    chk("E_trig", int'(trig), 0);

    // Reset pulse in the middle of a measurement.
    dly[0] = 10; wid[0] = 500;
    trig_q.delete();
    sweep(4'b0001, 1'b0);
    n = 0;
    while (trig_q.size() < 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (110) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("R_trig", int'(trig), 0);
    chk("R_distance", int'(distance), 0);
    chk("R_ch", int'(ch), 0);
    chk("R_err", int'(err), 0);
    chk("R_val", int'(val), 0);
    chk("R_busy", int'(busy), 0);
    exp_q.delete();
    v0 = val_cnt;
    repeat (600) @(negedge clk);
    chk("R_no_stale_val", val_cnt - v0, 0);
    chk("R_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hcsr04_scan.md
# hcsr04_scan

Multi-channel ultrasonic ranging controller: one measurement engine drives up to N HC-SR04-style sensors in round-robin order, producing a millimetre distance per ping. It replaces the single-sensor HCSR04 driver with parametrised channel count, timing and range, continuous scanning, echo timeout and over-range detection. It sits between the sensor pins (trig out, echo in) and the display/telemetry logic that consumes `val`-qualified distances.

## Interface
- `N_CH`, 4: number of sensor channels (1..8).
- `TRIG_CYCLES`, 500: trig pulse width in clocks (10 us at 50 MHz).
- `MM_CYCLES`, 292: clocks of echo-high per 1 mm of distance (5.83 us round trip at 50 MHz).
- `MAX_MM`, 4000: range limit in mm; distance saturates here.
- `WAIT_CYCLES`, 1_500_000: max clocks from trig fall to echo rise before timeout (30 ms).
- `GAP_CYCLES`, 3_000_000: quiet time after each ping before the next trig (60 ms).
- `DW`, 12: distance width; must satisfy 2^DW > MAX_MM.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a sweep; honoured only in IDLE.
- `cont` in 1: 1 = repeat sweeps until cleared; 0 = single sweep.
- `ch_en` in N_CH: channel enable mask, sampled at sweep start.
- `echo` in N_CH: asynchronous echo pins.
- `trig` out N_CH: trig pins, one-hot or zero.
- `distance` out DW: last result in mm.
- `ch` out $clog2(N_CH) (min 1): channel of last result.
- `err` out 1: last result is timeout or over-range.
- `val` out 1: one-cycle strobe qualifying `distance`/`ch`/`err`.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- Echo inputs pass through a 2-flop synchroniser per channel; only the selected channel's synchronised echo is used.
- States: IDLE, TRIG, WAIT_ECHO, MEASURE, GAP.
- IDLE: on `start`=1 and `ch_en`≠0, latch mask, select lowest enabled channel, go TRIG. `start` with mask 0 is ignored.
- TRIG: `trig[ch]`=1 for exactly TRIG_CYCLES clocks, then WAIT_ECHO.
- WAIT_ECHO: wait for synchronised echo 0→1 edge (echo already high on entry does not count); on edge clear counters, go MEASURE. After WAIT_CYCLES clocks without edge: emit result distance=0, err=1, go GAP.
- MEASURE: sub-counter counts clocks; each time it reaches MM_CYCLES-1 it wraps and mm counter increments. Echo 1→0: emit distance=mm count (floor), err=0, go GAP. If mm count reaches MAX_MM while echo still high: emit distance=MAX_MM, err=1, go GAP without waiting for echo.
- GAP: count GAP_CYCLES, then advance to next enabled channel (ascending, wrapping) and go TRIG. If the current channel was the last enabled one: go TRIG on the lowest enabled channel if `cont`=1 (mask re-sampled), else IDLE. `cont` is sampled at this decision only.
- Emit = drive `distance`, `ch`, `err` registered and pulse `val` for one cycle; outputs hold until the next emit.

## Timing
- Reset values: `trig`=0, `distance`=0, `ch`=0, `err`=0, `val`=0, `busy`=0, state IDLE, all counters 0.
- Reset mid-operation: `trig` low after the reset edge; no `val` for the aborted ping.
- `start` seen at edge k: `trig[ch]` high from edge k+1 through edge k+TRIG_CYCLES, low after.
- Echo-fall latency: `val` high in the cycle after the 3rd rising edge following the pin fall (2 sync + 1 register).
- Result = floor(echo_high_clocks / MM_CYCLES), ±1 mm from synchroniser skew.
- `start` during a sweep ignored; `val` never asserted twice within GAP_CYCLES.
- Echo on non-selected channels ignored.

## Structure
- Package `hcsr04_pkg`: state enum, default timing constants for 50 MHz, helper function for next-enabled-channel search.
- One sub-module `hcsr04_sync`: parametrised-width 2-flop echo synchroniser. Everything else in `hcsr04_scan`.

## Test plan
- N_CH=1, start, echo rises 200 us after trig falls, held 500 us -> one `val`, distance=85, err=0, ch=0, busy drops after GAP.
- N_CH=4, ch_en=4'b1010, cont=0, echoes 500 us / 1790 us -> trig order ch1 then ch3, results 85 then 306, then IDLE.
- Echo never rises (WAIT_CYCLES=10_000 bench override) -> val with distance=0, err=1 at trig-fall+10_000 clocks.
- Echo held high 30 ms -> val with distance=4000, err=1 at 4000·292 clocks after rise.
- cont=1, ch_en=4'b0011 for 3 sweeps then cont=0 -> pattern ch0,ch1 repeats 3x, stops after last ch1 GAP; start with ch_en=0 -> busy stays 0.
- rst low for one cycle mid-MEASURE -> trig/val/outputs at reset values next cycle, no stale result emitted.
